// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_add_cell.sv
// Single-bit full adder, purely combinational.
// Ports:
//   x, y : operand bits
//   z    : carry in
//   s    : sum bit (x ^ y ^ z)
//   co   : carry out (majority of x, y, z)
module full_add_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ z;
  assign co = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {c_out, sum} = a + b + c_in, one bit per clock, LSB
// first, through a single full_add_cell.
// Parameters:
//   WIDTH : operand/result width, 2..32
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin an addition (taken only while ready)
//   a, b, c_in  : operands and carry-in, captured on the accepting edge
//   ready       : controller idle
//   busy        : addition in progress
//   done        : one-cycle completion pulse
//   sum, c_out  : result of the last completed addition
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // One extra bit so the counter can never wrap within a run.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_co;

  full_add_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .z  (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      part  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            part  <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so that after WIDTH steps the
          // LSB-first stream lines up in natural bit order.
          part  <= {cell_s, part[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= cell_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sum   <= {cell_s, part[WIDTH-1:1]};
            c_out <= cell_co;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
